// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 640x480@60 raster scan-out of a 160x120 framebuffer.
// Each stored pixel is replicated 4x4. The block drives the DE-series VGA DAC pins.
// Optional build macro VGA_TEST_PATTERN_EN adds a colour-bar test pattern,
// which is selected at run time by test_sel.
module vga_fb_scanout #(
  parameter int unsigned H_VISIBLE               = 640,
  parameter int unsigned H_FRONT                 = 16,
  parameter int unsigned H_SYNC                  = 96,
  parameter int unsigned H_BACK                  = 48,
  parameter int unsigned V_VISIBLE               = 480,
  parameter int unsigned V_FRONT                 = 10,
  parameter int unsigned V_SYNC                  = 2,
  parameter int unsigned V_BACK                  = 33,
  parameter int unsigned BITS_PER_COLOUR_CHANNEL = 1
) (
  input  logic                                   CLOCK_50,
  input  logic                                   reset,
  output logic [14:0]                            mem_addr,
  output logic                                   mem_rd,
  input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0]   mem_data,
  input  logic                                   test_sel,
  output logic                                   frame_start,
  output logic                                   VGA_CLK,
  output logic                                   VGA_HS,
  output logic                                   VGA_VS,
  output logic                                   VGA_BLANK_N,
  output logic                                   VGA_SYNC_N,
  output logic [9:0]                             VGA_R,
  output logic [9:0]                             VGA_G,
  output logic [9:0]                             VGA_B
);

  localparam int unsigned BPC          = BITS_PER_COLOUR_CHANNEL;
  localparam int unsigned CW           = 3 * BPC;
  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned REP          = 10 / BPC + 1;

  logic          pix_en;
  logic          first_pix;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          h_last;
  logic          v_last;
  logic          visible;
  logic          hs_active;
  logic          vs_active;
  logic [7:0]    x;
  logic [6:0]    y;
  logic          pattern_on;
  logic [CW-1:0] colour;

  // MSB-aligned fill: repeat the channel bits and keep the top 10
  function automatic logic [9:0] expand(input logic [BPC-1:0] ch);
    logic [REP*BPC-1:0] ext;
    ext = {REP{ch}};
    return ext[REP*BPC-1 -: 10];
  endfunction

  // raster decode from the current counter values
  always_comb begin
    h_last    = (h_cnt == 10'(H_TOTAL - 1));
    v_last    = (v_cnt == 10'(V_TOTAL - 1));
    visible   = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    hs_active = (h_cnt >= 10'(H_SYNC_START)) && (h_cnt < 10'(H_SYNC_END));
    vs_active = (v_cnt >= 10'(V_SYNC_START)) && (v_cnt < 10'(V_SYNC_END));
    x         = h_cnt[9:2];
    y         = v_cnt[8:2];
  end

`ifdef VGA_TEST_PATTERN_EN
  assign pattern_on = test_sel;
  assign colour     = pattern_on ? CW'(x[7:5]) : mem_data;
`else
  logic unused_test_sel;
  assign unused_test_sel = test_sel;
  assign pattern_on      = 1'b0;
  assign colour          = mem_data;
`endif

  // framebuffer read request: y*160 + x as y*128 + y*32 + x, parked at 0 off-screen
  always_comb begin
    mem_addr = '0;
    mem_rd   = 1'b0;
    if (visible) begin
      mem_addr = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
      mem_rd   = ~pattern_on;
    end
  end

  assign VGA_SYNC_N = 1'b0;

  // pixel-enable toggle at half rate; VGA_CLK is its registered copy
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pix_en  <= 1'b0;
      VGA_CLK <= 1'b0;
    end else begin
      pix_en  <= ~pix_en;
      VGA_CLK <= pix_en;
    end
  end

  // raster counters and frame_start
  // The first pixel slot after reset holds (0,0) instead of advancing.
  // That slot is treated as entering the frame, so frame_start fires there.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      first_pix   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        if (first_pix) begin
          first_pix   <= 1'b0;
          frame_start <= 1'b1;
        end else if (h_last) begin
          h_cnt <= '0;
          if (v_last) begin
            v_cnt       <= '0;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // output registers load on pixel edges, one pixel period behind the counters.
  // RAM data for the current counters arrived one clock earlier.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pix_en && !first_pix) begin
      VGA_HS      <= ~hs_active;
      VGA_VS      <= ~vs_active;
      VGA_BLANK_N <= visible;
      if (visible) begin
        VGA_R <= expand(colour[2*BPC +: BPC]);
        VGA_G <= expand(colour[BPC +: BPC]);
        VGA_B <= expand(colour[0 +: BPC]);
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Read side of the 160x120 pixel framebuffer that the plot-style writers fill through x/y/colour/plot.
- Generates 640x480@60 timing from CLOCK_50 and reads one framebuffer word per pixel.
- Each stored pixel is replicated 4x4, and the block drives the DE-series VGA DAC pins.
- Sits between the framebuffer RAM read port and the board VGA pins.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, h front porch (pixels)
- H_SYNC, 96, h sync width
- H_BACK, 48, h back porch
- V_VISIBLE, 480, active lines
- V_FRONT, 10, v front porch (lines)
- V_SYNC, 2, v sync width
- V_BACK, 33, v back porch
- BITS_PER_COLOUR_CHANNEL, 1, bits per channel in each framebuffer word; word width = 3*BITS_PER_COLOUR_CHANNEL

Ports:
- CLOCK_50 input 1: 50 MHz clock, only clock
- reset input 1: synchronous, active-high reset
- mem_addr output 15: framebuffer read address = y*160 + x
- mem_rd output 1: read strobe, high only while counters are in the visible region
- mem_data input 3*BITS_PER_COLOUR_CHANNEL: RAM read data, valid 1 clock after mem_addr/mem_rd
- test_sel input 1: test-pattern select (see Optional Feature)
- frame_start output 1: one-clock pulse at pixel (0,0)
- VGA_CLK output 1: pixel clock (25 MHz)
- VGA_HS output 1: h sync, active low
- VGA_VS output 1: v sync, active low
- VGA_BLANK_N output 1: low outside the active area
- VGA_SYNC_N output 1: tied 0
- VGA_R, VGA_G, VGA_B output 10 each: channel data, MSB-aligned, each channel's bits replicated to fill 10 bits

Behaviour:
- Decided: one clock, CLOCK_50; reset is synchronous and active-high on port reset.
- pix_en toggle: 0 in reset, inverts every clock. VGA_CLK = registered pix_en.
- h_cnt 0..H_TOTAL-1 (H_TOTAL=800); v_cnt 0..V_TOTAL-1 (V_TOTAL=525). Both advance only on pix_en=1 cycles.
- Wrap: h 799->0, and v increments on that same pix_en cycle; v 524->0 when h wraps.
- Visible region: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- Address, combinational from counters: x = h_cnt[9:2] (0..159), y = v_cnt[8:2] (0..119), mem_addr = {y,7'b0} + {y,5'b0} + x, 15-bit, no overflow.
- Outside the visible region: mem_addr = 0, mem_rd = 0.
- Latency: counters at (h,v) after pix_en edge k -> RAM data valid during k+2 -> output registers load on edge k+2, which is a pix_en edge.
- Net result: VGA_R/G/B, HS, VS and BLANK_N all lag the counters by exactly one pixel period.
- Sync and blank are derived from the same counter values and delayed by the same amount, so they stay aligned with the colour data.
- HS low for h_cnt in [656,751]; VS low for v_cnt in [490,491]; BLANK_N = visible.
- When BLANK_N=0, VGA_R/G/B = 0 regardless of mem_data.
- frame_start = 1 for one clock, on the pix_en edge where the counters enter (0,0).
- Reset values, all applied on the next edge, including mid-frame:
  - h_cnt = 0, v_cnt = 0, pix_en = 0
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0
  - VGA_R/G/B = 0, frame_start = 0, VGA_CLK = 0
- Resumption after reset: frame_start fires on the first pix_en edge after reset is released, and the frame restarts cleanly.
- No handshake with writers: the framebuffer is dual-port, and tearing is acceptable.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined, test_sel=1: mem_data is ignored and the colour word = x[7:5] (bars, 32 stored pixels wide: 0,1,2,3,4). mem_rd is forced 0.
- Defined, test_sel=0: normal operation.
- Undefined: test_sel is ignored, no pattern logic is synthesised, behaviour is normal.

Test Plan:
- Reset 10 clocks, then release -> HS=1, VS=1, BLANK_N=0, RGB=0 during reset; frame_start pulses exactly once within 2 clocks of release, and again every 800*525*2 = 840000 clocks.
- Run one line -> HS low for exactly 192 clocks (96 pixels), starting 2*(656+1) clocks after h_cnt=0; BLANK_N high for exactly 1280 clocks per visible line.
- RAM model (1-clk latency) with mem[addr] = addr[2:0]; at h_cnt=4, v_cnt=8 -> mem_addr=321, and one pixel later VGA_R/G/B reflect word 3'b001: B=10'h3FF, R=G=0.
- Check address range and read strobe -> mem_addr never exceeds 19199; mem_rd=0 for all h_cnt>=640 or v_cnt>=480; RGB=0 while BLANK_N=0 even with mem_data=3'b111.
- Assert reset at h_cnt=300, v_cnt=200 -> next edge counters=0 and outputs at reset values; after release, VS low 2 lines starting at line 490 of the new frame.
- With VGA_TEST_PATTERN_EN defined and test_sel=1 -> colour word 0 for x 0..31, 1 for x 32..63, …, 4 for x 128..159; mem_rd stays 0.
